// File: rtl/zero_scan_ctrl_pkg.sv
// ============================================================================
// zero_scan_ctrl_pkg : shared FSM encoding and default operand geometry
// Revision: 1.0
// ============================================================================
`default_nettype none

package zero_scan_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 64;
  localparam int DEFAULT_CHUNK_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width; a single-chunk operand still gets a 1-bit index.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zero_scan_ctrl_if.sv
// ============================================================================
// zero_scan_ctrl_if : start/abort request and scan-result bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface zero_scan_ctrl_if
  import zero_scan_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) ();

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);

  logic                  start_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  zero_o;
  logic [IDX_W-1:0]      chunk_idx_o;

  modport master (
    output start_i, data_i, abort_i,
    input  busy_o, done_o, zero_o, chunk_idx_o
  );

  modport slave (
    input  start_i, data_i, abort_i,
    output busy_o, done_o, zero_o, chunk_idx_o
  );

endinterface

`default_nettype wire

// File: rtl/zero_scan_ctrl_or_n.sv
// ============================================================================
// zero_scan_ctrl_or_n : GATE_WIDTH-input OR reduction slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module zero_scan_ctrl_or_n #(
  parameter int GATE_WIDTH = 8
) (
  input  wire logic [GATE_WIDTH-1:0] a,
  output logic                       y
);

  assign y = |a;

endmodule

`default_nettype wire

// File: rtl/zero_scan_ctrl.sv
// ============================================================================
// zero_scan_ctrl : multi-cycle zero test, one chunk per cycle, early exit
// Revision: 1.0
// ============================================================================
`default_nettype none

module zero_scan_ctrl
  import zero_scan_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  zero_scan_ctrl_if.slave bus
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_width_check
    $error("zero_scan_ctrl: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] operand, operand_nxt;
  logic                  zero_q, zero_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic                  done_q, done_nxt;

  logic [CHUNK_WIDTH-1:0] chunks [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] slice;
  logic                   slice_nz;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunks
    assign chunks[g] = operand[g*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  assign slice = chunks[cnt];

  zero_scan_ctrl_or_n #(
    .GATE_WIDTH (CHUNK_WIDTH)
  ) u_or_slice (
    .a (slice),
    .y (slice_nz)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      operand <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      operand <= operand_nxt;
      zero_q  <= zero_nxt;
      idx_q   <= idx_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    operand_nxt = operand;
    zero_nxt    = zero_q;
    idx_nxt     = idx_q;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // Start beats a simultaneous abort: abort only matters in SCAN.
        if (bus.start_i) begin
          operand_nxt = bus.data_i;
          cnt_nxt     = '0;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort_i) begin
          state_nxt = IDLE;
        end else if (slice_nz) begin
          zero_nxt  = 1'b0;
          idx_nxt   = cnt;
          state_nxt = DONE;
        end else if (cnt == LAST_IDX) begin
          zero_nxt  = 1'b1;
          idx_nxt   = LAST_IDX;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = done_q;
  assign bus.zero_o      = zero_q;
  assign bus.chunk_idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_zero_scan_ctrl.sv
// ============================================================================
// tb_zero_scan_ctrl : directed vector table plus abort/reset corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_zero_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  zero_scan_ctrl_if #(.DATA_WIDTH(64), .CHUNK_WIDTH(8)) bus ();

  zero_scan_ctrl #(.DATA_WIDTH(64), .CHUNK_WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] data;
    int          lat;
    logic        zero;
    logic [2:0]  idx;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the accept edge until done_o is seen, or -1.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (bus.done_o) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  task automatic run_scan(input string name, input logic [63:0] data, input int lat,
                          input logic zero, input logic [2:0] idx);
    int got;
    bus.data_i  = data;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.data_i  = {$urandom, $urandom};
    wait_done(20, got);
    check({name, "_lat"}, 64'(got), 64'(lat));
    check({name, "_zero"}, {63'd0, bus.zero_o}, {63'd0, zero});
    check({name, "_idx"}, {61'd0, bus.chunk_idx_o}, {61'd0, idx});
  endtask

  initial begin
    int got;
    vecs[0] = '{64'h0000_0000_0000_0000, 9, 1'b1, 3'd7};
    vecs[1] = '{64'h0000_0000_0000_0001, 2, 1'b0, 3'd0};
    vecs[2] = '{64'h8000_0000_0000_0000, 9, 1'b0, 3'd7};
    vecs[3] = '{64'h0000_0100_0000_0000, 7, 1'b0, 3'd5};
    vecs[4] = '{64'h00FF_0000_0000_0000, 8, 1'b0, 3'd6};
    vecs[5] = '{64'h0000_0000_0000_FF00, 3, 1'b0, 3'd1};
    vecs[6] = '{64'h0000_0000_8000_0000, 5, 1'b0, 3'd3};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 3'd0};
    vecs[8] = '{64'h0000_0010_0000_0000, 6, 1'b0, 3'd4};

    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    bus.data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_done", {63'd0, bus.done_o}, 64'd0);
    check("rst_zero", {63'd0, bus.zero_o}, 64'd0);
    check("rst_idx", {61'd0, bus.chunk_idx_o}, 64'd0);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    rst = 1'b0;
    tick();

    // Back-to-back: each next start is issued in the IDLE cycle carrying done_o.
    for (int i = 0; i < 9; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].data, vecs[i].lat, vecs[i].zero, vecs[i].idx);
    end

    // Abort mid-scan with start held high and data changing; results stay at idx 5.
    run_scan("pre_abort", 64'h0000_0100_0000_0000, 7, 1'b0, 3'd5);
    tick();
    bus.data_i  = 64'h0;
    bus.start_i = 1'b1;
    tick();
    bus.data_i  = 64'h0000_0000_0000_0001;
    tick();
    tick();
    tick();
    check("abort_busy_before", {63'd0, bus.busy_o}, 64'd1);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("abort_busy_after", {63'd0, bus.busy_o}, 64'd0);
    watch_no_done("abort_no_done", 12);
    check("abort_zero_kept", {63'd0, bus.zero_o}, 64'd0);
    check("abort_idx_kept", {61'd0, bus.chunk_idx_o}, 64'd5);

    // Start held through the whole scan must not recapture the operand.
    bus.data_i  = 64'h0;
    bus.start_i = 1'b1;
    tick();
    bus.data_i = 64'h0000_0000_0000_0001;
    wait_done(20, got);
    bus.start_i = 1'b0;
    check("hold_lat", 64'(got), 64'd9);
    check("hold_zero", {63'd0, bus.zero_o}, 64'd1);
    check("hold_idx", {61'd0, bus.chunk_idx_o}, 64'd7);
    tick();
    check("hold_idle", {63'd0, bus.busy_o}, 64'd0);

    // Start and abort together in IDLE: start wins.
    bus.data_i  = 64'h0000_0000_0000_0001;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    wait_done(20, got);
    check("start_wins_lat", 64'(got), 64'd2);
    check("start_wins_zero", {63'd0, bus.zero_o}, 64'd0);

    // Reset four cycles into a zero scan.
    tick();
    bus.data_i  = 64'h0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("midrst_done", {63'd0, bus.done_o}, 64'd0);
    check("midrst_zero", {63'd0, bus.zero_o}, 64'd0);
    check("midrst_idx", {61'd0, bus.chunk_idx_o}, 64'd0);
    watch_no_done("midrst_no_done", 12);
    run_scan("post_rst", 64'h00FF_0000_0000_0000, 8, 1'b0, 3'd6);

    // Reset while in DONE suppresses the pulse.
    tick();
    bus.data_i  = 64'h0000_0000_0000_0001;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    check("donerst_busy_pre", {63'd0, bus.busy_o}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("donerst_done", {63'd0, bus.done_o}, 64'd0);
    watch_no_done("donerst_no_done", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
